coletor_resultados: RTL and testbench

COLETOR_RESULTADOS -- requirements
Module: coletor_resultados

---
 rtl/coletor_resultados.sv | 69 ++++++
 tb/tb_coletor_resultados.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/coletor_resultados.sv
// coletor_resultados: 4-entry FWFT result FIFO capturing on pronto rising edges; COLETOR_ACUMULADOR_EN adds running sum soma
module coletor_resultados (
  input  logic        clk,
  input  logic        reset,
  input  logic        pronto,
  input  logic [15:0] resultado,
  input  logic        ler,
  output logic [15:0] dado,
  output logic        valido,
  output logic        cheio,
  output logic [2:0]  contagem,
  output logic        perdido
`ifdef COLETOR_ACUMULADOR_EN
  ,
  output logic [19:0] soma
`endif
);
  logic        pronto_ant_q, pronto_ant_d;
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        perdido_q, perdido_d;
  logic [15:0] mem_q [4];
  logic [15:0] mem_d [4];
  logic        push, pop, acc;
  assign valido   = cnt_q != 3'd0;
  assign cheio    = cnt_q == 3'd4;
  assign contagem = cnt_q;
  assign perdido  = perdido_q;
  assign dado     = valido ? mem_q[head_q] : 16'h0000;
  // edge detect, pointer/occupancy update; a pop in the same cycle frees the slot for a push when full
  always_comb begin
    push         = pronto & ~pronto_ant_q;
    pop          = valido & ler;
    acc          = push & (~cheio | pop);
    pronto_ant_d = pronto;
    head_d       = pop ? head_q + 2'd1 : head_q;
    tail_d       = acc ? tail_q + 2'd1 : tail_q;
    cnt_d        = cnt_q + {2'b00, acc} - {2'b00, pop};
    perdido_d    = perdido_q | (push & cheio & ~pop);
    mem_d        = mem_q;
    if (acc) mem_d[tail_q] = resultado;
  end
  // control state; pronto_ant resets high so a pronto held through reset release is not captured
  always_ff @(posedge clk) begin
    if (reset) begin
      pronto_ant_q <= 1'b1;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      cnt_q        <= 3'd0;
      perdido_q    <= 1'b0;
    end else begin
      pronto_ant_q <= pronto_ant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      perdido_q    <= perdido_d;
    end
  end
  // storage is left uninitialised; it is never visible while empty
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef COLETOR_ACUMULADOR_EN
  logic [19:0] soma_q, soma_d;
  assign soma = soma_q;
  // running sum of accepted results only, modulo 2^20
  always_comb soma_d = acc ? soma_q + {4'h0, resultado} : soma_q;
  // accumulator register
  always_ff @(posedge clk) soma_q <= reset ? 20'd0 : soma_d;
`endif
endmodule

// File: tb/tb_coletor_resultados.sv
// tb_coletor_resultados: directed table-driven bench for coletor_resultados
module tb_coletor_resultados;
  logic        clk = 1'b0;
  logic        reset, pronto, ler;
  logic [15:0] resultado;
  logic [15:0] dado;
  logic        valido, cheio, perdido;
  logic [2:0]  contagem;
`ifdef COLETOR_ACUMULADOR_EN
  logic [19:0] soma;
`endif
  int n_chk = 0;
  int n_fail = 0;

  coletor_resultados dut (
    .clk(clk), .reset(reset), .pronto(pronto), .resultado(resultado), .ler(ler),
    .dado(dado), .valido(valido), .cheio(cheio), .contagem(contagem), .perdido(perdido)
`ifdef COLETOR_ACUMULADOR_EN
    , .soma(soma)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pr;
    logic [15:0] res;
    logic        ler;
    logic [15:0] d;
    logic        v, c;
    logic [2:0]  n;
    logic        p;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic rst, input logic pr, input logic [15:0] res, input logic l,
                     input logic [15:0] d, input logic v, input logic c, input logic [2:0] n, input logic p);
    vec_t e;
    e.rst = rst; e.pr = pr; e.res = res; e.ler = l;
    e.d = d; e.v = v; e.c = c; e.n = n; e.p = p;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic pr, input logic [15:0] res, input logic l);
    reset = rst; pronto = pr; resultado = res; ler = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pronto = 1'b0; resultado = 16'h0; ler = 1'b0;
    // reset state, then pronto held high: exactly one capture
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 16'h1234, 0, 16'h1234, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // fill to full, overflow drop, drain in order, underflow ignored
    for (int k = 1; k <= 4; k++) begin
      add(0, 1, 16'(k), 0, 16'h0001, 1, k == 4, 3'(k), 0);
      add(0, 0, 0, 0, 16'h0001, 1, k == 4, 3'(k), 0);
    end
    add(0, 1, 16'h0005, 0, 16'h0001, 1, 1, 4, 1);
    add(0, 0, 0, 0, 16'h0001, 1, 1, 4, 1);
    add(0, 0, 0, 1, 16'h0002, 1, 0, 3, 1);
    add(0, 0, 0, 1, 16'h0003, 1, 0, 2, 1);
    add(0, 0, 0, 1, 16'h0004, 1, 0, 1, 1);
    add(0, 0, 0, 1, 16'h0000, 0, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 0, 0, 0, 1);
    // full with simultaneous push and pop
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 1, 16'(k * 'h11), 0, 16'h0011, 1, k == 4, 3'(k), 0);
      add(0, 0, 0, 0, 16'h0011, 1, k == 4, 3'(k), 0);
    end
    add(0, 1, 16'h00AA, 1, 16'h0022, 1, 1, 4, 0);
    add(0, 0, 0, 1, 16'h0033, 1, 0, 3, 0);
    add(0, 0, 0, 1, 16'h0044, 1, 0, 2, 0);
    add(0, 0, 0, 1, 16'h00AA, 1, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
    // one entry with simultaneous push and pop
    add(0, 1, 16'h0055, 0, 16'h0055, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0055, 1, 0, 1, 0);
    add(0, 1, 16'h0066, 1, 16'h0066, 1, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
    // pronto held through reset release gives no capture
    add(1, 1, 16'h0777, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0777, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0777, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0BEE, 0, 16'h0BEE, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0BEE, 1, 0, 1, 0);
    // reset wins over push and pop
    add(0, 1, 16'h0101, 0, 16'h0BEE, 1, 0, 2, 0);
    add(0, 0, 0, 0, 16'h0BEE, 1, 0, 2, 0);
    add(0, 1, 16'h0102, 0, 16'h0BEE, 1, 0, 3, 0);
    add(0, 0, 0, 0, 16'h0BEE, 1, 0, 3, 0);
    add(1, 1, 16'h0103, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].pr, tv[i].res, tv[i].ler);
      chk($sformatf("v%0d dado", i), 32'(dado), 32'(tv[i].d));
      chk($sformatf("v%0d valido", i), 32'(valido), 32'(tv[i].v));
      chk($sformatf("v%0d cheio", i), 32'(cheio), 32'(tv[i].c));
      chk($sformatf("v%0d contagem", i), 32'(contagem), 32'(tv[i].n));
      chk($sformatf("v%0d perdido", i), 32'(perdido), 32'(tv[i].p));
    end

    // sustained push/pop at one edge every two cycles
    for (int i = 0; i < 20; i++) begin
      logic [15:0] val;
      val = 16'(i * 'h1111 + 7);
      drive(0, 1, val, 1);
      chk($sformatf("stream%0d dado", i), 32'(dado), 32'(val));
      chk($sformatf("stream%0d contagem", i), 32'(contagem), 32'd1);
      drive(0, 0, 0, 1);
      chk($sformatf("stream%0d drained", i), 32'(contagem), 32'd0);
    end
    chk("stream perdido", 32'(perdido), 32'd0);

`ifdef COLETOR_ACUMULADOR_EN
    drive(1, 0, 0, 0);
    chk("soma reset", 32'(soma), 32'd0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 16'hFFFF, 1);
      drive(0, 0, 0, 1);
    end
    chk("soma 17x", 32'(soma), 32'h0FFEF);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 16'hFFFF, 0);
      drive(0, 0, 0, 0);
    end
    chk("soma drop excluded", 32'(soma), 32'h3FFFC);
    chk("soma drop perdido", 32'(perdido), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
